stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter FRAME_PERIOD, default 16384: clock cycles per frame tick (≥2).
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles any stage may stay enabled (≥2).
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 pause_i  in  1  level; holds the sequencer in IDLE at frame boundaries.
REQ-006 step_i  in  1  pulse; starts one frame while paused.
REQ-007 d_inp_i, d_act_i, d_disp_i  in  1 each  done strobes from the input, action and display stages.
REQ-008 e_inp_o, e_act_o, e_disp_o  out  1 each  stage enables.
REQ-009 state_o  out  2  current state: IDLE=00, INPUT=01, ACTION=11, DISPLAY=10.
REQ-010 frame_cnt_o  out  8  completed-frame counter.
REQ-011 overrun_o  out  1  one-cycle pulse: a frame tick occurred outside IDLE.
REQ-012 timeout_o  out  1  sticky: a stage watchdog fired.

Function
REQ-013 Free-running frame timer: counts 0..FRAME_PERIOD-1 and wraps; frame_tick is true in the cycle where timer = FRAME_PERIOD-1.
REQ-014 Enables are decoded from registered state only: e_inp_o=(INPUT), e_act_o=(ACTION), e_disp_o=(DISPLAY); exactly one or none is high.
REQ-015 IDLE→INPUT when frame_tick=1 and pause_i=0, or when pause_i=1 and step_i=1; otherwise stay in IDLE.
REQ-016 INPUT→ACTION on d_inp_i=1; ACTION→DISPLAY on d_act_i=1; DISPLAY→IDLE on d_disp_i=1.
REQ-017 Transitions take effect in the cycle after the done strobe is sampled; the enable drops in that same cycle.
REQ-018 Done strobes are ignored in any state other than the one they belong to; done strobes in IDLE are ignored.
REQ-019 frame_cnt_o increments by 1 on DISPLAY→IDLE and wraps from 255 to 0.
REQ-020 frame_tick in INPUT, ACTION or DISPLAY: overrun_o=1 for the following cycle; the frame continues and the tick is discarded (no queued start).
REQ-021 A per-stage cycle counter clears on every state entry and increments each cycle spent in the stage.
REQ-022 pause_i is sampled only in IDLE; asserting it mid-frame never aborts the frame.
REQ-023 step_i is ignored when pause_i=0 or state≠IDLE.

Reset
REQ-024 With reset_i=1 at a clock edge, the following are cleared: state=IDLE, frame timer=0, stage counter=0, frame_cnt_o=0, overrun_o=0, timeout_o=0, all enables 0.
REQ-025 Reset mid-frame aborts immediately with no counter update; frame timer restarts at 0 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro SEQ_WATCHDOG_EN.
REQ-027 Defined: when the stage counter = TIMEOUT-1 and the stage's done strobe is 0, the next state is IDLE, timeout_o sets and stays set until reset, and frame_cnt_o is not incremented; a done strobe in the same cycle takes priority and no timeout occurs.
REQ-028 Undefined: no watchdog logic; stages wait indefinitely for their done strobe, and timeout_o is tied to 0.

Verification (FRAME_PERIOD=16, TIMEOUT=8)
REQ-029 Reset deasserts at cycle 0, done strobes return 2 cycles after each enable rises → state_o 01 at cycle 16, 11 at 19, 10 at 22, 00 at 25; frame_cnt_o=1 at cycle 25.
REQ-030 pause_i=1 across several ticks → state stays 00; a one-cycle step_i pulse → state_o=01 on the next cycle; frame_cnt_o increments once when the frame completes.
REQ-031 d_act_i held at 0 (watchdog on) → e_act_o high exactly 8 cycles, then state 00 and timeout_o=1 until reset; frame_cnt_o unchanged. Watchdog off → e_act_o stays high indefinitely.
REQ-032 d_disp_i delayed so that the frame's tick arrives in DISPLAY → overrun_o pulses once for 1 cycle; the next start comes at the following tick.
REQ-033 d_inp_i pulsed while in ACTION and in IDLE → no state change; reset_i pulsed mid-ACTION → state 00 and all counters 0 on the next cycle.
REQ-034 Start frame_cnt_o at 255 → one completed frame wraps it to 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: frame-timed INPUT -> ACTION -> DISPLAY stage sequencer with pause/single-step.
// Optional per-stage watchdog is compiled in when SEQ_WATCHDOG_EN is defined.
module stage_sequencer #(
    parameter int FRAME_PERIOD = 16384,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pause_i,
    input  logic       step_i,
    input  logic       d_inp_i,
    input  logic       d_act_i,
    input  logic       d_disp_i,
    output logic       e_inp_o,
    output logic       e_act_o,
    output logic       e_disp_o,
    output logic [1:0] state_o,
    output logic [7:0] frame_cnt_o,
    output logic       overrun_o,
    output logic       timeout_o
);
    localparam int TW = $clog2(FRAME_PERIOD);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        INPUT   = 2'b01,
        ACTION  = 2'b11,
        DISPLAY = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          frame_tick, done, wd;

    // Next-state: frame timer, stage FSM, stage counter, frame counter and status flags
    always_comb begin
        frame_tick = timer_q == TW'(FRAME_PERIOD - 1);
        timer_d    = frame_tick ? '0 : timer_q + 1'b1;
        done       = (state_q == INPUT && d_inp_i) || (state_q == ACTION && d_act_i) ||
                     (state_q == DISPLAY && d_disp_i);
`ifdef SEQ_WATCHDOG_EN
        wd         = state_q != IDLE && !done && cnt_q == CW'(TIMEOUT - 1);
`else
        wd         = 1'b0;
`endif
        state_d    = state_q;
        if (state_q == IDLE)
            state_d = (pause_i ? step_i : frame_tick) ? INPUT : IDLE;
        else if (done)
            state_d = state_q == INPUT ? ACTION : state_q == ACTION ? DISPLAY : IDLE;
        else if (wd)
            state_d = IDLE;
        cnt_d      = state_d != state_q ? '0 : cnt_q + 1'b1;
        fcnt_d     = fcnt_q + {7'd0, state_q == DISPLAY && d_disp_i};
        overrun_d  = frame_tick && state_q != IDLE;
        timeout_d  = timeout_q || wd;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign e_inp_o     = state_q == INPUT;
    assign e_act_o     = state_q == ACTION;
    assign e_disp_o    = state_q == DISPLAY;
    assign state_o     = state_q;
    assign frame_cnt_o = fcnt_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench for stage_sequencer (FRAME_PERIOD=16, TIMEOUT=8)
module tb_stage_sequencer;
    logic clk = 1'b0, reset_i = 1'b1, pause_i = 1'b0, step_i = 1'b0;
    logic m_inp = 1'b0, m_act = 1'b0, m_disp = 1'b0, a_inp = 1'b0, a_act = 1'b0, a_disp = 1'b0;
    logic d_inp_i, d_act_i, d_disp_i, e_inp_o, e_act_o, e_disp_o, overrun_o, timeout_o, rp = 1'b0;
    logic [1:0] state_o;
    logic [7:0] frame_cnt_o;
    logic [14:0] obs;
    int lat_inp = 2, lat_act = 2, lat_disp = 2, ki = 0, ka = 0, kd = 0;
    int cyc = 0, ep = 0, checks = 0, errors = 0;

    typedef struct {string n; int e; int at; logic [14:0] v; logic [14:0] m;} exp_t;
    exp_t sb[$];

    localparam logic [14:0] M_ST = 15'h6000, M_FC = 15'h1FE0, M_EN = 15'h001C;
    localparam logic [14:0] M_OV = 15'h0002, M_TO = 15'h0001, M_ALL = 15'h7FFF;

    stage_sequencer #(.FRAME_PERIOD(16), .TIMEOUT(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .pause_i(pause_i), .step_i(step_i),
        .d_inp_i(d_inp_i), .d_act_i(d_act_i), .d_disp_i(d_disp_i),
        .e_inp_o(e_inp_o), .e_act_o(e_act_o), .e_disp_o(e_disp_o),
        .state_o(state_o), .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    assign obs      = {state_o, frame_cnt_o, e_inp_o, e_act_o, e_disp_o, overrun_o, timeout_o};
    assign d_inp_i  = a_inp | m_inp;
    assign d_act_i  = a_act | m_act;
    assign d_disp_i = a_disp | m_disp;

    // cycle index since the last reset, and an epoch that advances on every reset assertion
    always @(posedge clk) begin
        cyc <= reset_i ? 0 : cyc + 1;
        ep  <= ep + int'(reset_i && !rp);
        rp  <= reset_i;
    end

    // stage responder: strobe done lat_* cycles after the stage enable rises (-1 = never)
    always @(negedge clk) begin
        a_inp  <= e_inp_o && ki == lat_inp;
        a_act  <= e_act_o && ka == lat_act;
        a_disp <= e_disp_o && kd == lat_disp;
        ki     <= e_inp_o ? ki + 1 : 0;
        ka     <= e_act_o ? ka + 1 : 0;
        kd     <= e_disp_o ? kd + 1 : 0;
    end

    function automatic void push(string n, int e, int at, logic [1:0] s, logic [7:0] f,
                                 logic [2:0] en, logic o, logic t, logic [14:0] m);
        sb.push_back('{n, e, at, {s, f, en, o, t}, m});
    endfunction

    task automatic wait_to(int e, int at);
        for (int n = 0; n < 6000 && !(ep == e && cyc >= at); n++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; pause_i = 1'b0; step_i = 1'b0; {m_inp, m_act, m_disp} = 3'b000;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        lat_inp = 2; lat_act = 2; lat_disp = 2;
        do_reset(); e = ep;
        push("reset_state", e, 0, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("reset_idle_pre_tick", e, 15, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        while (sb.size() > 0) begin
            exp_t x = sb.pop_front();
            wait_to(x.e, x.at);
            checks++;
            if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
            end
        end
    endtask

    task automatic test_frame();
        int e;
        lat_inp = 2; lat_act = 2; lat_disp = 2;
        do_reset(); e = ep;
        push("frame_input", e, 16, 2'b01, 8'd0, 3'b100, 1'b0, 1'b0, M_ALL);
        push("frame_input_hold", e, 18, 2'b01, 8'd0, 3'b100, 1'b0, 1'b0, M_ST | M_EN);
        push("frame_action", e, 19, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("frame_display", e, 22, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ALL);
        push("frame_display_hold", e, 24, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ST | M_FC);
        push("frame_done", e, 25, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ALL);
        push("frame2_input", e, 32, 2'b01, 8'd1, 3'b100, 1'b0, 1'b0, M_ALL);
        push("frame2_done", e, 41, 2'b00, 8'd2, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        while (sb.size() > 0) begin
            exp_t x = sb.pop_front();
            wait_to(x.e, x.at);
            checks++;
            if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
            end
        end
    endtask

    task automatic test_pause_step();
        int e;
        lat_inp = 2; lat_act = 2; lat_disp = 2;
        do_reset(); e = ep;
        pause_i = 1'b1;
        push("pause_tick1", e, 16, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ST | M_EN);
        push("pause_tick2", e, 32, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ST | M_EN);
        push("pause_tick3", e, 48, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ST | M_EN);
        push("step_start", e, 51, 2'b01, 8'd0, 3'b100, 1'b0, 1'b0, M_ALL);
        push("step_action", e, 54, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ST | M_EN);
        push("step_display", e, 57, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ST | M_EN);
        push("step_done", e, 60, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        push("step_once", e, 64, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        push("step_unpaused_ignored", e, 71, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_EN);
        push("unpaused_start", e, 80, 2'b01, 8'd1, 3'b100, 1'b0, 1'b0, M_ST | M_EN);
        push("pause_midframe_act", e, 83, 2'b11, 8'd1, 3'b010, 1'b0, 1'b0, M_ST | M_EN);
        push("pause_midframe_disp", e, 86, 2'b10, 8'd1, 3'b001, 1'b0, 1'b0, M_ST | M_EN);
        push("pause_midframe_done", e, 89, 2'b00, 8'd2, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        push("pause_holds_again", e, 96, 2'b00, 8'd2, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        fork
            begin
                wait_to(e, 50); step_i = 1'b1;
                wait_to(e, 51); step_i = 1'b0;
                wait_to(e, 66); pause_i = 1'b0;
                wait_to(e, 70); step_i = 1'b1;
                wait_to(e, 71); step_i = 1'b0;
                wait_to(e, 82); pause_i = 1'b1;
            end
            while (sb.size() > 0) begin
                exp_t x = sb.pop_front();
                wait_to(x.e, x.at);
                checks++;
                if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
                end
            end
        join
    endtask

    task automatic test_watchdog();
        int e;
        lat_inp = 2; lat_disp = 2;
`ifdef SEQ_WATCHDOG_EN
        lat_act = 7;
        do_reset(); e = ep;
        push("wd_act_enter", e, 19, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("wd_act_last", e, 26, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ST | M_EN | M_TO);
        push("wd_done_priority", e, 27, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ALL);
        push("wd_frame1_done", e, 30, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_FC | M_TO);
        push("wd_pre_act", e, 34, 2'b01, 8'd1, 3'b100, 1'b0, 1'b0, M_ST | M_EN);
        push("wd_act2_enter", e, 35, 2'b11, 8'd1, 3'b010, 1'b0, 1'b0, M_ALL);
        push("wd_act2_eighth", e, 42, 2'b11, 8'd1, 3'b010, 1'b0, 1'b0, M_ALL);
        push("wd_fired", e, 43, 2'b00, 8'd1, 3'b000, 1'b0, 1'b1, M_ALL);
        push("wd_sticky", e, 48, 2'b01, 8'd1, 3'b100, 1'b0, 1'b1, M_ALL);
        fork
            begin
                wait_to(e, 31); lat_act = -1;
            end
`else
        lat_act = -1;
        do_reset(); e = ep;
        push("nowd_act_enter", e, 19, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("nowd_act_past_limit", e, 27, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("nowd_no_overrun_yet", e, 31, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("nowd_overrun", e, 32, 2'b11, 8'd0, 3'b010, 1'b1, 1'b0, M_ALL);
        push("nowd_overrun_end", e, 33, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("nowd_still_waiting", e, 60, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        fork
            begin
            end
`endif
            while (sb.size() > 0) begin
                exp_t x = sb.pop_front();
                wait_to(x.e, x.at);
                checks++;
                if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
                end
            end
        join
    endtask

    task automatic test_overrun();
        int e;
        lat_inp = 5; lat_act = 5; lat_disp = 4;
        do_reset(); e = ep;
        push("ovr_action", e, 22, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ST | M_EN);
        push("ovr_display", e, 28, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ST | M_EN);
        push("ovr_tick_cycle", e, 31, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ALL);
        push("ovr_pulse", e, 32, 2'b10, 8'd0, 3'b001, 1'b1, 1'b0, M_ALL);
        push("ovr_pulse_end", e, 33, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ALL);
        push("ovr_tick_dropped", e, 47, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ALL);
        push("ovr_next_start", e, 48, 2'b01, 8'd1, 3'b100, 1'b0, 1'b0, M_ALL);
        while (sb.size() > 0) begin
            exp_t x = sb.pop_front();
            wait_to(x.e, x.at);
            checks++;
            if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
            end
        end
    endtask

    task automatic test_ignore_reset();
        int e;
        lat_inp = 2; lat_act = 2; lat_disp = 2;
        do_reset(); e = ep;
        push("ign_inp_in_idle", e, 6, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("ign_act_disp_in_idle", e, 8, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("ign_pre_action", e, 20, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ST | M_EN);
        push("ign_inp_in_action", e, 21, 2'b11, 8'd0, 3'b010, 1'b0, 1'b0, M_ALL);
        push("ign_display", e, 22, 2'b10, 8'd0, 3'b001, 1'b0, 1'b0, M_ST | M_EN);
        push("ign_frame_done", e, 25, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        push("rst_pre_action", e, 35, 2'b11, 8'd1, 3'b010, 1'b0, 1'b0, M_ALL);
        push("rst_mid_action", e + 1, 0, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("rst_timer_idle", e + 1, 15, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("rst_timer_restart", e + 1, 16, 2'b01, 8'd0, 3'b100, 1'b0, 1'b0, M_ALL);
        fork
            begin
                wait_to(e, 5); m_inp = 1'b1;
                wait_to(e, 6); m_inp = 1'b0;
                wait_to(e, 7); {m_act, m_disp} = 2'b11;
                wait_to(e, 8); {m_act, m_disp} = 2'b00;
                wait_to(e, 20); m_inp = 1'b1;
                wait_to(e, 21); m_inp = 1'b0;
                wait_to(e, 36); reset_i = 1'b1;
                wait_to(e + 1, 0); reset_i = 1'b0;
            end
            while (sb.size() > 0) begin
                exp_t x = sb.pop_front();
                wait_to(x.e, x.at);
                checks++;
                if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
                end
            end
        join
    endtask

    task automatic test_wrap();
        int e;
        lat_inp = 2; lat_act = 2; lat_disp = 2;
        do_reset(); e = ep;
        push("wrap_at_255", e, 4089, 2'b00, 8'd255, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        push("wrap_last_display", e, 4104, 2'b10, 8'd255, 3'b001, 1'b0, 1'b0, M_ALL);
        push("wrap_to_zero", e, 4105, 2'b00, 8'd0, 3'b000, 1'b0, 1'b0, M_ALL);
        push("wrap_then_one", e, 4121, 2'b00, 8'd1, 3'b000, 1'b0, 1'b0, M_ST | M_FC);
        while (sb.size() > 0) begin
            exp_t x = sb.pop_front();
            wait_to(x.e, x.at);
            checks++;
            if (ep != x.e || cyc != x.at || (obs & x.m) !== (x.v & x.m)) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d", x.n, cyc, obs & x.m, x.v & x.m, x.at);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pause_step();
        test_watchdog();
        test_overrun();
        test_ignore_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
